// File: rtl/mux16_scan_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : mux16_scan_ctrl_if
// Purpose  : Handshake and multiplexer-side signals of the 16:1 scan sequencer
// Revision : 1.0 - initial release
//============================================================================
interface mux16_scan_ctrl_if;
    logic        start;
    logic        cont;
    logic [15:0] chan_en;
    logic        mux_y;
    logic [3:0]  sel;
    logic [15:0] data_out;
    logic        busy;
    logic        done;

    modport master (
        output start, cont, chan_en, mux_y,
        input  sel, data_out, busy, done
    );

    modport slave (
        input  start, cont, chan_en, mux_y,
        output sel, data_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mux16_scan_ctrl.sv
`default_nettype none
//============================================================================
// Module   : mux16_scan_ctrl
// Purpose  : Steps a 16:1 mux select through enabled channels, samples each
//            after a settle window and presents the result as a 16-bit word
// Revision : 1.0 - initial release
//============================================================================
module mux16_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    mux16_scan_ctrl_if.slave bus
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
    localparam logic [3:0] c_settle    = 4'(SETTLE);

    logic [1:0]  r_state;
    logic [3:0]  r_sel;
    logic [3:0]  r_cnt;
    logic [15:0] r_en_q;
    logic [15:0] r_shadow;
    logic [15:0] r_data;
    logic        r_busy;
    logic        r_done;

    logic [15:0] w_above;
    logic [3:0]  w_first;
    logic [3:0]  w_next;
    logic [15:0] w_shadow_upd;
    logic        w_launch;

    function automatic logic [3:0] f_lowest(input logic [15:0] v);
        f_lowest = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) f_lowest = 4'(i);
        end
    endfunction

    assign w_above      = r_en_q & (16'hFFFE << r_sel);
    assign w_next       = f_lowest(w_above);
    assign w_first      = f_lowest(bus.chan_en);
    assign w_shadow_upd = r_shadow | ({15'd0, bus.mux_y} << r_sel);
    assign w_launch     = ((r_state == c_st_idle) && bus.start) ||
                          ((r_state == c_st_done) && bus.cont);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_sel    <= 4'd0;
            r_cnt    <= 4'd0;
            r_en_q   <= 16'h0000;
            r_shadow <= 16'h0000;
            r_data   <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                c_st_idle: ;
                c_st_settle: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_shadow <= w_shadow_upd;
                        if (w_above != 16'h0000) begin
                            r_sel <= w_next;
                            r_cnt <= c_settle;
                        end else begin
                            // Masking with en_q keeps an empty-mask pass at zero
                            r_data  <= w_shadow_upd & r_en_q;
                            r_done  <= 1'b1;
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    if (!bus.cont) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // An empty mask still spends one cycle in SETTLE, so DONE lands on edge 1
            if (w_launch) begin
                r_en_q   <= bus.chan_en;
                r_shadow <= 16'h0000;
                r_state  <= c_st_settle;
                r_busy   <= 1'b1;
                if (bus.chan_en != 16'h0000) begin
                    r_sel <= w_first;
                    r_cnt <= c_settle;
                end else begin
                    r_cnt <= 4'd0;
                end
            end
        end
    end

    assign bus.sel      = r_sel;
    assign bus.data_out = r_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: doc/mux16_scan_ctrl.md
# mux16_scan_ctrl

Sequencer that sits directly upstream of the 16:1 bit multiplexer. It drives the multiplexer's four select lines through all enabled channels in ascending order and samples the multiplexer output for each one. The captured bits are assembled into a 16-bit parallel word, turning the multiplexer plus this controller into a masked, settle-timed parallel capture unit with a start/done handshake.

## Interface
- SETTLE, default 1: extra cycles the select must be held stable before sampling; legal range 0..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  scan request; sampled only in IDLE
- cont  input  1  continuous mode; sampled in DONE
- chan_en  input  16  channel enable mask; bit n enables channel n; latched at scan start
- mux_y  input  1  multiplexer output
- sel  output  4  select to multiplexer; sel[0]→s0, sel[1]→s1, sel[2]→s2, sel[3]→s3; registered
- data_out  output  16  last completed scan word; disabled channels read 0; registered
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  one-cycle pulse; data_out is valid and new in the same cycle

## Operation
- Reset (async, rst=1): state=IDLE, sel=0, data_out=0, shadow=0, en_q=0, cnt=0, busy=0, done=0.
- IDLE:
  - On start=1, latch en_q=chan_en and clear shadow.
  - If chan_en≠0: sel=lowest set bit index, cnt=SETTLE, go to SETTLE.
  - If chan_en=0: go to DONE with data_out=0.
- SETTLE:
  - If cnt>0: cnt−1.
  - If cnt=0: shadow[sel]=mux_y (sample edge).
  - If other enabled channels remain above sel: sel=next set bit of en_q, cnt=SETTLE, stay in SETTLE.
  - Otherwise: data_out=shadow including this bit, go to DONE.
- DONE (exactly one cycle, done=1, busy=1):
  - If cont=1: behave as IDLE with start=1. chan_en is re-latched; empty-mask rule applies.
  - Otherwise go to IDLE.
- start is ignored outside IDLE; no queuing.
- chan_en changes during a scan are ignored.
- sel holds its last value in IDLE.
- Skipped (disabled) channels take zero cycles and are never selected.
- Bits of data_out for disabled channels are 0.
- data_out changes only on entry to DONE; it is stable otherwise.
- Next-channel search is a combinational priority encoder over en_q masked to bits above sel.

## Timing
- Each enabled channel occupies SETTLE+1 cycles.
- mux_y is sampled at the last rising edge of that window.
- Let edge 0 be the edge sampling start=1 in IDLE, and N the number of set bits in chan_en.
  - N≥1: the DONE-entry edge is N·(SETTLE+1). done=1 and the new data_out are visible in the following cycle.
  - N=0: the DONE-entry edge is edge 1.
- busy rises at edge 0 and falls at the edge leaving DONE with cont=0. Minimum idle gap between scans is 1 cycle (IDLE).
- In continuous mode, the next scan's first sel appears at the edge leaving DONE. The scan period is N·(SETTLE+1)+1 cycles.
- mux_y must be stable at its sample edge. The combinational mux path from sel is covered by SETTLE.
- rst mid-scan aborts immediately:
  - no done pulse;
  - data_out cleared to 0;
  - partial shadow discarded.

## Test plan
- Reset with rst=1 mid-operation → sel=0, data_out=16'h0000, busy=0, done=0 asynchronously. No done after release until a new start.
- SETTLE=1, chan_en=16'hFFFF, mux inputs=16'hA5C3, start pulse → sel steps 0..15, each held 2 cycles. done at edge 32, data_out=16'hA5C3, busy low one cycle later.
- SETTLE=0, chan_en=16'h00F0, inputs=16'hFFFF → sel visits 4,5,6,7 only. done at edge 4, data_out=16'h00F0.
- chan_en=16'h0000, start → no sel change, done at edge 1, data_out=16'h0000.
- cont=1, chan_en=16'h8001, SETTLE=2, inputs change 16'h0001→16'h8000 between scans:
  - scan 1: data_out=16'h0001;
  - scan 2: data_out=16'h8000;
  - done pulses 7 cycles apart.
- start reasserted while busy, and chan_en changed mid-scan → no restart, captured mask unchanged. rst asserted at edge 5 of a full scan → done never pulses, data_out=0.
